// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control sequencer: FSM states,
// NOP constants for bubble consumers and the data-stall run counter helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DSTALL   = 2'd1,
    ST_BRANCH   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // NOP encoding loaded into ID/EX when idex_bubble is asserted
  localparam logic [5:0] NOP_FUNC  = 6'b000000;
  localparam logic       NOP_REGWR = 1'b0;

  localparam int unsigned RUN_W = 4;

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and taken-branch statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: PC / IF/ID / ID/EX enables, flushes and bubbles,
// branch-redirect FSM, data-stall watchdog and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_DSTALL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_branch,
  input  logic             ex_taken,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] taken_count,
  output logic             hazard_timeout
);

  state_t           r_state;
  logic             r_taken_q;
  logic [RUN_W-1:0] r_run;
  logic             r_timeout;

  logic             w_redirect;
  logic             w_stall_inc;
  logic             w_taken_inc;

  assign w_redirect = (r_state == ST_REDIRECT);

  // Reset overrides combinationally so the pipe is frozen the moment reset rises
  always_comb begin
    pc_we       = 1'b1;
    pc_sel      = 1'b0;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_redirect) begin
      pc_sel      = r_taken_q;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_stall_req) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (if_stall_req) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_taken_q <= 1'b0;
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_redirect && ex_branch) begin
        r_state   <= ST_REDIRECT;
        r_taken_q <= ex_taken;
      end else if (id_stall_req) begin
        r_state <= ST_DSTALL;
      end else if (if_stall_req) begin
        r_state <= ST_BRANCH;
      end else begin
        r_state <= ST_RUN;
      end

      // REDIRECT ignores a pending data stall, so the run length holds there
      if (!id_stall_req) begin
        r_run <= '0;
      end else if (!w_redirect) begin
        r_run <= run_inc(r_run);
        if ({{(32-RUN_W){1'b0}}, r_run} >= MAX_DSTALL) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign hazard_timeout = r_timeout;
  assign w_stall_inc    = ~pc_we;
  assign w_taken_inc    = w_redirect & r_taken_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_taken_inc),
    .q     (taken_count)
  );

endmodule
